// File: rtl/conv_frame_ctrl_if.sv
// Port bundle for conv_frame_ctrl: source pixel stream, datapath drive/return,
// tagged results and frame status.
interface conv_frame_ctrl_if #(
   parameter int WORD_SIZE = 8,
   parameter int ROW_SIZE  = 540,
   parameter int NUM_ROWS  = 540
);
   localparam int RW = $clog2(NUM_ROWS);
   localparam int CW = $clog2(ROW_SIZE);

   // A pixel moves on a rising edge where in_valid && in_ready; the source holds
   // in_pixel while in_valid waits, and in_ready is high for the whole RUN state.
   logic                 start;
   logic [WORD_SIZE-1:0] in_pixel;
   logic                 in_valid;
   logic                 in_ready;
   logic [WORD_SIZE-1:0] conv_pixel;
   logic                 conv_en;
   logic [WORD_SIZE-1:0] conv_result;
   logic [WORD_SIZE-1:0] out_pixel;
   logic                 out_valid;
   logic [RW-1:0]        out_row;
   logic [CW-1:0]        out_col;
   logic                 busy;
   logic                 done;
   logic [1:0]           state;

   // master: source and datapath side; slave: the frame controller.
   modport master (
      output start, in_pixel, in_valid, conv_result,
      input  in_ready, conv_pixel, conv_en, out_pixel, out_valid, out_row, out_col,
             busy, done, state
   );
   modport slave (
      input  start, in_pixel, in_valid, conv_result,
      output in_ready, conv_pixel, conv_en, out_pixel, out_valid, out_row, out_col,
             busy, done, state
   );
endinterface

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for a 3x3 streaming convolution: gates the datapath, flushes
// the line buffer at frame end and tags each retired centre as interior or border.
module conv_frame_ctrl #(
   parameter int WORD_SIZE = 8,
   parameter int ROW_SIZE  = 540,
   parameter int NUM_ROWS  = 540,
   parameter int PIPE_LAT  = 3,
   parameter int LAG       = ROW_SIZE + PIPE_LAT + 2
) (
   input logic              clk,
   input logic              rst_n,
   conv_frame_ctrl_if.slave bus
);
   localparam int RW    = $clog2(NUM_ROWS);
   localparam int CW    = $clog2(ROW_SIZE);
   localparam int NPIX  = ROW_SIZE * NUM_ROWS;
   localparam int TOTAL = NPIX + LAG;
   localparam int NW    = $clog2(TOTAL + 1);
   localparam int AW    = $clog2(LAG + 1);

   localparam logic [NW-1:0] LAST_PIX   = NW'(NPIX - 1);
   localparam logic [NW-1:0] LAST_EN    = NW'(TOTAL - 1);
   localparam logic [AW-1:0] LAG_V      = AW'(LAG);
   localparam logic [CW-1:0] COL_MAX    = CW'(ROW_SIZE - 1);
   localparam logic [CW-1:0] COL_IN_MAX = CW'(ROW_SIZE - 2);
   localparam logic [RW-1:0] ROW_MAX    = RW'(NUM_ROWS - 1);
   localparam logic [RW-1:0] ROW_IN_MAX = RW'(NUM_ROWS - 2);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_t;

   state_t               state;
   logic [NW-1:0]        in_cnt;      // counts accepted pixels, then flush cycles
   logic [AW-1:0]        adv_cnt;
   logic [RW-1:0]        pos_row;
   logic [CW-1:0]        pos_col;
   logic                 in_ready_r, flush_en, adv_d, ret_d, busy_r, done_r, out_valid_r;
   logic [WORD_SIZE-1:0] out_pixel_r;
   logic [RW-1:0]        out_row_r;
   logic [CW-1:0]        out_col_r;
   logic                 xfer, conv_en;

   assign xfer    = bus.in_valid & in_ready_r;
   assign conv_en = xfer | flush_en;

   assign bus.in_ready   = in_ready_r;
   assign bus.conv_en    = conv_en;
   assign bus.conv_pixel = in_ready_r ? bus.in_pixel : '0;
   assign bus.out_pixel  = out_pixel_r;
   assign bus.out_valid  = out_valid_r;
   assign bus.out_row    = out_row_r;
   assign bus.out_col    = out_col_r;
   assign bus.busy       = busy_r;
   assign bus.done       = done_r;
   assign bus.state      = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         in_cnt      <= '0;
         adv_cnt     <= '0;
         pos_row     <= '0;
         pos_col     <= '0;
         in_ready_r  <= 1'b0;
         flush_en    <= 1'b0;
         adv_d       <= 1'b0;
         ret_d       <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         out_valid_r <= 1'b0;
         out_pixel_r <= '0;
         out_row_r   <= '0;
         out_col_r   <= '0;
      end else begin
         // conv_result reflects the previous advance, so capture one edge later.
         adv_d       <= conv_en;
         ret_d       <= conv_en && (adv_cnt == LAG_V);
         done_r      <= 1'b0;
         out_valid_r <= 1'b0;
         if (conv_en && (adv_cnt != LAG_V)) adv_cnt <= adv_cnt + 1'b1;

         if (adv_d && ret_d) begin
            out_pixel_r <= bus.conv_result;
            out_valid_r <= (pos_row != '0) && (pos_row <= ROW_IN_MAX) &&
                           (pos_col != '0) && (pos_col <= COL_IN_MAX);
            out_row_r   <= pos_row;
            out_col_r   <= pos_col;
            if (pos_col == COL_MAX) begin
               pos_col <= '0;
               pos_row <= (pos_row == ROW_MAX) ? '0 : pos_row + 1'b1;
            end else begin
               pos_col <= pos_col + 1'b1;
            end
         end

         case (state)
            IDLE: if (bus.start) begin
               state      <= RUN;
               in_ready_r <= 1'b1;
               busy_r     <= 1'b1;
               in_cnt     <= '0;
               adv_cnt    <= '0;
               pos_row    <= '0;
               pos_col    <= '0;
               out_row_r  <= '0;
               out_col_r  <= '0;
            end
            RUN: if (xfer) begin
               in_cnt <= in_cnt + 1'b1;
               if (in_cnt == LAST_PIX) begin
                  state      <= FLUSH;
                  in_ready_r <= 1'b0;
                  flush_en   <= 1'b1;
               end
            end
            FLUSH: begin
               in_cnt <= in_cnt + 1'b1;
               if (in_cnt == LAST_EN) begin
                  state    <= DONE;
                  flush_en <= 1'b0;
                  done_r   <= 1'b1;
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_r <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Bench for conv_frame_ctrl on a 5x4 frame with a behavioural 3x3 Laplacian
// datapath (centre 8, neighbours -1, clamped to 0..255).
module tb_conv_frame_ctrl;
   localparam int R    = 5;
   localparam int NR   = 4;
   localparam int LAG  = 10;
   localparam int NPIX = R * NR;
   localparam int RW   = $clog2(NR);
   localparam int CW   = $clog2(R);
   localparam int EW   = RW + CW + 8;
   localparam int LBD  = 2 * R + 3;

   logic clk = 1'b0;
   logic rst_n;
   logic start, in_valid;
   logic [7:0] in_pixel;

   int checks = 0;
   int failures = 0;
   int en_cnt = 0;
   int done_cnt = 0;
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] mon_got, mon_exp;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   conv_frame_ctrl_if #(.WORD_SIZE(8), .ROW_SIZE(R), .NUM_ROWS(NR)) bus ();

   conv_frame_ctrl #(.WORD_SIZE(8), .ROW_SIZE(R), .NUM_ROWS(NR), .PIPE_LAT(3), .LAG(LAG)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   assign bus.start    = start;
   assign bus.in_valid = in_valid;
   assign bus.in_pixel = in_pixel;

   // ---------------- datapath stand-in ----------------
   // Line buffer, then window sum, two register stages, clamp: centre result
   // lands LAG advances after the centre pixel is fed.
   logic [7:0] lb [0:LBD-1] = '{default: 8'd0};
   int st0 = 0, st1 = 0, st2 = 0;
   logic [7:0] st3 = 8'd0;
   assign bus.conv_result = st3;

   function automatic int lap(input logic [7:0] w [0:LBD-1]);
      int s;
      s = 8 * int'(w[R+1]);
      for (int dr = -1; dr <= 1; dr++)
         for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0) s -= int'(w[R + 1 - dr * R - dc]);
      return s;
   endfunction

   function automatic logic [7:0] clamp8(input int v);
      if (v < 0) return 8'd0;
      if (v > 255) return 8'd255;
      return 8'(v);
   endfunction

   always @(posedge clk) begin
      if (bus.conv_en) begin
         for (int k = LBD - 1; k > 0; k--) lb[k] <= lb[k-1];
         lb[0] <= bus.conv_pixel;
         st0 <= lap(lb);
         st1 <= st0;
         st2 <= st1;
         st3 <= clamp8(st2);
      end
   end

   // ---------------- stimulus images and hand-computed results ----------------
   function automatic logic [7:0] pix(input int img, input int idx);
      int r, c, v;
      r = idx / R;
      c = idx % R;
      v = 0;
      case (img)
         0: begin
            v = 7;
            if (r == 1 && c == 1) v += 30;
            if (r == 1 && c == 3) v += 9;
            if (r == 2 && c == 3) v += 5;
         end
         1: v = 10;
         default: v = (r == 2 && c == 2) ? 100 : 0;
      endcase
      return 8'(v);
   endfunction

   // Interior results in raster order (1,1)(1,2)(1,3)(2,1)(2,2)(2,3).
   logic [7:0] exp_tab [0:2][0:5] = '{
      '{8'd240, 8'd0, 8'd67, 8'd0, 8'd0,   8'd31},
      '{8'd0,   8'd0, 8'd0,  8'd0, 8'd0,   8'd0},
      '{8'd0,   8'd0, 8'd0,  8'd0, 8'd255, 8'd0}
   };

   // ---------------- scoreboard ----------------
   task automatic push_expected(input int img);
      for (int k = 0; k < 6; k++)
         exp_q.push_back({RW'(1 + k / 3), CW'(1 + k % 3), exp_tab[img][k]});
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.conv_en === 1'b1) en_cnt++;
      if (bus.done === 1'b1) done_cnt++;
      if (bus.out_valid === 1'b1) begin
         mon_got = {bus.out_row, bus.out_col, bus.out_pixel};
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL out_unexpected actual=(%0d,%0d,%0d) required=none",
                     bus.out_row, bus.out_col, bus.out_pixel);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp) begin
               failures++;
               $display("FAIL out_result actual=(%0d,%0d,%0d) required=(%0d,%0d,%0d)",
                        mon_got[EW-1 -: RW], mon_got[CW+7:8], mon_got[7:0],
                        mon_exp[EW-1 -: RW], mon_exp[CW+7:8], mon_exp[7:0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_counts();
      en_cnt = 0;
      done_cnt = 0;
   endtask

   task automatic check_counts(input string tag, input int exp_en, input int exp_done);
      chk({tag, "_conv_en_cycles"}, 32'(en_cnt), 32'(exp_en));
      chk({tag, "_done_pulses"}, 32'(done_cnt), 32'(exp_done));
      chk({tag, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
      chk({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
   endtask

   // stall: one idle cycle after every pixel; poke: start during RUN, FLUSH and DONE.
   task automatic run_frame(input int img, input bit stall, input bit poke);
      bit seen;
      push_expected(img);
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      for (int p = 0; p < NPIX; p++) begin
         in_valid = 1'b1;
         in_pixel = pix(img, p);
         if (poke && p == 7) start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         if (stall) begin
            in_valid = 1'b0;
            in_pixel = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
         end
      end
      in_valid = 1'b0;
      in_pixel = 8'($urandom_range(0, 255));
      if (poke) begin
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) seen = 1'b1;
      end
      chk("done_seen", 32'(seen), 32'd1);
      if (poke && seen) begin
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      in_pixel = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_conv_en", 32'(bus.conv_en), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_out_pixel", 32'(bus.out_pixel), 32'd0);
      chk("rst_out_row", 32'(bus.out_row), 32'd0);
      chk("rst_out_col", 32'(bus.out_col), 32'd0);
      chk("rst_state", 32'(bus.state), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // continuous stream
      clear_counts();
      run_frame(0, 1'b0, 1'b0);
      idle(5);
      check_counts("s1", 30, 1);

      // in_valid 1,0,1,0
      clear_counts();
      run_frame(0, 1'b1, 1'b0);
      idle(5);
      check_counts("s2", 30, 1);

      // flat frame, then single impulse
      clear_counts();
      run_frame(1, 1'b0, 1'b0);
      idle(5);
      check_counts("s3a", 30, 1);
      clear_counts();
      run_frame(2, 1'b0, 1'b0);
      idle(5);
      check_counts("s3b", 30, 1);

      // asynchronous reset while pixel 9 is offered
      clear_counts();
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      for (int p = 0; p < 9; p++) begin
         in_valid = 1'b1;
         in_pixel = pix(0, p);
         @(posedge clk); #1;
      end
      in_pixel = pix(0, 9);
      #1;
      chk("s4_pre_conv_en", 32'(bus.conv_en), 32'd1);
      chk("s4_pre_busy", 32'(bus.busy), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("s4_rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("s4_rst_conv_en", 32'(bus.conv_en), 32'd0);
      chk("s4_rst_busy", 32'(bus.busy), 32'd0);
      chk("s4_rst_done", 32'(bus.done), 32'd0);
      chk("s4_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("s4_rst_out_row", 32'(bus.out_row), 32'd0);
      chk("s4_rst_out_col", 32'(bus.out_col), 32'd0);
      chk("s4_rst_state", 32'(bus.state), 32'd0);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("s4_no_done", 32'(done_cnt), 32'd0);
      clear_counts();
      run_frame(0, 1'b0, 1'b0);
      idle(5);
      check_counts("s4", 30, 1);

      // start pulses during RUN, FLUSH and DONE are ignored
      clear_counts();
      run_frame(0, 1'b0, 1'b1);
      idle(40);
      check_counts("s5a", 30, 1);

      // back-to-back frames, second start the cycle after done
      clear_counts();
      run_frame(0, 1'b0, 1'b0);
      run_frame(0, 1'b0, 1'b0);
      idle(5);
      check_counts("s5b", 60, 2);

      idle(5);
      chk("sb_final_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end
endmodule
